// File: rtl/cpu_pkg.sv
// Shared opcode map, sequencer state encoding and decode strobe bundle
// used by the PC sequencer and its next-PC/decode block.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  // Opcodes (5-bit); CMP, ALU and MOV are families, matched with casez.
  localparam logic [4:0] OPC_NOP  = 5'b00000;
  localparam logic [4:0] OPC_CALL = 5'b00001;
  localparam logic [4:0] OPC_CMP  = 5'b0001?;
  localparam logic [4:0] OPC_JMPR = 5'b00100;
  localparam logic [4:0] OPC_JMPI = 5'b00101;
  localparam logic [4:0] OPC_ALU  = 5'b01???;
  localparam logic [4:0] OPC_MOV  = 5'b1100?;
  localparam logic [4:0] OPC_RTN  = 5'b11100;
  localparam logic [4:0] OPC_STP  = 5'b11111;

  typedef struct packed {
    logic rd_wen;
    logic push_up;
    logic pop;
    logic halt;
  } dec_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational instruction decode: next PC (1- or 2-word length, jumps,
// conditional compare skips) and the register/stack strobes of the opcode.
module pc_next_calc
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OPC_W  = 5
) (
  input  logic [DATA_W-1:0] i_pc,
  input  logic [DATA_W-1:0] i_instr,
  input  logic [DATA_W-1:0] i_imm,
  input  logic [DATA_W-1:0] i_rddata,
  input  logic              i_jump_cond,
  output logic [DATA_W-1:0] o_next_pc,
  output dec_t              o_dec
);

  logic [OPC_W-1:0]  w_opc;
  logic [4:0]        w_op;
  logic [DATA_W-1:0] w_pc_inc1;
  logic [DATA_W-1:0] w_pc_inc2;
  logic [DATA_W-1:0] w_pc_cmp;
  logic              w_unused_bits;

  assign w_opc         = i_instr[DATA_W-1 -: OPC_W];
  assign w_op          = 5'(w_opc);
  assign w_pc_inc1     = i_pc + DATA_W'(1);
  assign w_pc_inc2     = i_pc + DATA_W'(2);
  assign w_pc_cmp      = i_pc + DATA_W'(1) + DATA_W'(i_instr[1:0]);
  assign w_unused_bits = ^i_instr[DATA_W-OPC_W-1:2];

  always_comb begin
    o_next_pc = w_pc_inc1;
    o_dec     = '0;
    casez (w_op)
      OPC_NOP: ;
      OPC_CALL: begin
        o_next_pc     = i_imm;
        o_dec.rd_wen  = 1'b1;
        o_dec.push_up = 1'b1;
      end
      OPC_CMP: begin
        if (i_jump_cond) o_next_pc = w_pc_cmp;
      end
      OPC_JMPR: o_next_pc = i_rddata;
      OPC_JMPI: o_next_pc = i_imm;
      OPC_ALU, OPC_MOV: begin
        // Odd opcodes carry an immediate word, so skip over it.
        o_dec.rd_wen = 1'b1;
        if (w_op[0]) o_next_pc = w_pc_inc2;
      end
      OPC_RTN: begin
        o_next_pc = i_rddata;
        o_dec.pop = 1'b1;
      end
      default: begin
        // STP and every unassigned opcode stop in place.
        o_next_pc  = i_pc;
        o_dec.halt = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: RUN/STALL/HALT control, PC register, fetch
// addresses, retire strobes and a saturating retired-instruction counter.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OPC_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_instr,
  input  logic [DATA_W-1:0] i_imm,
  input  logic [DATA_W-1:0] i_rddata,
  input  logic              i_jump_cond,
  input  logic              i_mem_ready,
  input  logic              i_resume,
  output logic [DATA_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_instr_addr1,
  output logic [DATA_W-1:0] o_instr_addr2,
  output logic              o_retire,
  output logic              o_rd_wen,
  output logic              o_push_up,
  output logic              o_pop,
  output logic              o_halted,
  output logic [CNT_W-1:0]  o_retired_cnt
);

  state_e            r_state;
  state_e            w_state_next;
  logic [DATA_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] w_next_pc;
  dec_t              w_dec;
  logic              w_retire;

  pc_next_calc #(
    .DATA_W (DATA_W),
    .OPC_W  (OPC_W)
  ) u_pc_next_calc (
    .i_pc        (r_pc),
    .i_instr     (i_instr),
    .i_imm       (i_imm),
    .i_rddata    (i_rddata),
    .i_jump_cond (i_jump_cond),
    .o_next_pc   (w_next_pc),
    .o_dec       (w_dec)
  );

  // rst_n gates retire so no strobe escapes while reset is held.
  assign w_retire = (r_state == ST_RUN) && i_mem_ready && rst_n;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (!i_mem_ready)    w_state_next = ST_STALL;
        else if (w_dec.halt) w_state_next = ST_HALT;
      end
      ST_STALL: if (i_mem_ready) w_state_next = ST_RUN;
      ST_HALT:  if (i_resume)    w_state_next = ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_retire)
        r_pc <= w_next_pc;
      else if (r_state == ST_HALT && i_resume)
        r_pc <= r_pc + DATA_W'(1);
      if (w_retire && r_cnt != '1)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_pc          = r_pc;
  assign o_instr_addr1 = r_pc;
  assign o_instr_addr2 = r_pc + DATA_W'(1);
  assign o_retire      = w_retire;
  assign o_rd_wen      = w_retire & w_dec.rd_wen;
  assign o_push_up     = w_retire & w_dec.push_up;
  assign o_pop         = w_retire & w_dec.pop;
  assign o_halted      = (r_state == ST_HALT);
  assign o_retired_cnt = r_cnt;

endmodule
